// File: rtl/ps2_mouse_init_seq.sv
// PS/2 mouse bring-up sequencer: scripts reset/self-test/rate/resolution/stream-enable, checks ACKs, retries.
// Define PS2_WHEEL_DETECT_EN to add the wheel-unlock knock (F3 C8/64/50, F2) and ID capture.
module ps2_mouse_init_seq #(
  parameter logic [7:0]  SAMPLE_RATE  = 8'd100,
  parameter logic [7:0]  RESOLUTION   = 8'd2,
  parameter logic [23:0] ACK_TIMEOUT  = 24'd1_000_000,
  parameter logic [25:0] BAT_TIMEOUT  = 26'd40_000_000,
  parameter logic [2:0]  MAX_RETRIES  = 3'd3,
  parameter logic [25:0] FAIL_HOLDOFF = 26'd20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       tx_busy,
  input  logic       tx_error,
  output logic [7:0] tx_data,
  output logic       tx_load,
  output logic       rx_enable,
  output logic       mouse_ready,
  output logic       init_fail,
  output logic       wheel_present,
  output logic [3:0] seq_state
);

  typedef enum logic [3:0] {
    S_SEND = 4'd0, S_WAIT_TX = 4'd1, S_WAIT_RSP = 4'd2,
    S_RETRY = 4'd3, S_FAIL = 4'd4, S_RUN = 4'd5
  } state_t;

`ifdef PS2_WHEEL_DETECT_EN
  localparam int         NUM_STEPS = 13;
  localparam logic [3:0] ID_STEP   = 4'd7;
`else
  localparam int         NUM_STEPS = 6;
`endif
  localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);

  function automatic logic [7:0] step_cmd(input logic [3:0] s);
`ifdef PS2_WHEEL_DETECT_EN
    case (s)
      4'd0:    step_cmd = 8'hFF;
      4'd1:    step_cmd = 8'hF3;
      4'd2:    step_cmd = 8'hC8;
      4'd3:    step_cmd = 8'hF3;
      4'd4:    step_cmd = 8'h64;
      4'd5:    step_cmd = 8'hF3;
      4'd6:    step_cmd = 8'h50;
      4'd7:    step_cmd = 8'hF2;
      4'd8:    step_cmd = 8'hF3;
      4'd9:    step_cmd = SAMPLE_RATE;
      4'd10:   step_cmd = 8'hE8;
      4'd11:   step_cmd = RESOLUTION;
      default: step_cmd = 8'hF4;
    endcase
`else
    case (s)
      4'd0:    step_cmd = 8'hFF;
      4'd1:    step_cmd = 8'hF3;
      4'd2:    step_cmd = SAMPLE_RATE;
      4'd3:    step_cmd = 8'hE8;
      4'd4:    step_cmd = RESOLUTION;
      default: step_cmd = 8'hF4;
    endcase
`endif
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [1:0]  exp_q, exp_d;
  logic [25:0] cnt_q, cnt_d;
  logic [2:0]  retry_q, retry_d;
  logic        load_q, load_d;
  logic [7:0]  data_q, data_d;
  logic        saw_aa_q, saw_aa_d;
  logic        wheel_q, wheel_d;

  logic [1:0]  exp_last;
  logic [7:0]  exp_byte;
  logic        id_slot, rsp_ok, timeout;
  logic [25:0] limit;

  // What the device owes us for the current step/expectation pointer.
  always_comb begin
    exp_last = (step_q == 4'd0) ? 2'd2 : 2'd0;
    exp_byte = 8'hFA;
    id_slot  = 1'b0;
    if (step_q == 4'd0) begin
      case (exp_q)
        2'd1:    exp_byte = 8'hAA;
        2'd2:    exp_byte = 8'h00;
        default: exp_byte = 8'hFA;
      endcase
    end
`ifdef PS2_WHEEL_DETECT_EN
    if (step_q == ID_STEP) begin
      exp_last = 2'd1;
      id_slot  = (exp_q == 2'd1);
    end
`endif
    limit   = (step_q == 4'd0 && exp_q == 2'd1) ? BAT_TIMEOUT : 26'(ACK_TIMEOUT);
    timeout = (cnt_q == limit - 26'd1);
    rsp_ok  = id_slot || (rx_byte == exp_byte);
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    load_d   = load_q;
    data_d   = data_q;
    saw_aa_d = saw_aa_q;
    wheel_d  = wheel_q;
    case (state_q)
      S_SEND: begin
        data_d = step_cmd(step_q);
        if (load_q && tx_busy) begin
          load_d  = 1'b0;
          state_d = S_WAIT_TX;
        end else begin
          load_d = 1'b1;
        end
      end
      S_WAIT_TX: begin
        if (tx_error) state_d = S_RETRY;
        else if (!tx_busy) begin
          state_d = S_WAIT_RSP;
          cnt_d   = '0;
        end
      end
      S_WAIT_RSP: begin
        cnt_d = cnt_q + 26'd1;
        if (rx_valid) begin
          if (rsp_ok) begin
            cnt_d = '0;
            if (id_slot) wheel_d = (rx_byte == 8'h03);
            if (exp_q == exp_last) begin
              exp_d   = '0;
              retry_d = '0;
              if (step_q == LAST_STEP) begin
                state_d  = S_RUN;
                saw_aa_d = 1'b0;
              end else begin
                step_d  = step_q + 4'd1;
                state_d = S_SEND;
              end
            end else begin
              exp_d = exp_q + 2'd1;
            end
          end else begin
            state_d = S_RETRY;
          end
        end else if (timeout) begin
          state_d = S_RETRY;
        end
      end
      S_RETRY: begin
        exp_d   = '0;
        cnt_d   = '0;
        retry_d = retry_q + 3'd1;
        state_d = (retry_q + 3'd1 >= MAX_RETRIES) ? S_FAIL : S_SEND;
      end
      S_FAIL: begin
        cnt_d = cnt_q + 26'd1;
        if (cnt_q == FAIL_HOLDOFF - 26'd1) begin
          state_d = S_SEND;
          step_d  = '0;
          exp_d   = '0;
          retry_d = '0;
          wheel_d = 1'b0;
        end
      end
      S_RUN: begin
        // AA then 00 back-to-back means the device reset itself; BAT already done, skip FF.
        if (rx_valid) begin
          if (saw_aa_q && rx_byte == 8'h00) begin
            state_d  = S_SEND;
            step_d   = 4'd1;
            exp_d    = '0;
            retry_d  = '0;
            saw_aa_d = 1'b0;
          end else begin
            saw_aa_d = (rx_byte == 8'hAA);
          end
        end
      end
      default: state_d = S_SEND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_SEND;
      step_q   <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      retry_q  <= '0;
      load_q   <= 1'b0;
      data_q   <= 8'h00;
      saw_aa_q <= 1'b0;
      wheel_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      load_q   <= load_d;
      data_q   <= data_d;
      saw_aa_q <= saw_aa_d;
      wheel_q  <= wheel_d;
    end
  end

  assign tx_data     = data_q;
  assign tx_load     = load_q;
  assign rx_enable   = !((state_q == S_SEND && load_q) || state_q == S_WAIT_TX);
  assign mouse_ready = (state_q == S_RUN);
  assign init_fail   = (state_q == S_FAIL);
  assign seq_state   = state_q;
`ifdef PS2_WHEEL_DETECT_EN
  assign wheel_present = wheel_q;
`else
  assign wheel_present = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Scoreboard bench: a mouse/writer model answers the sequencer; expected command stream is derived from the script.
module tb_ps2_mouse_init_seq;
  localparam logic [23:0] ACK = 24'd150;
  localparam logic [25:0] BAT = 26'd400;
  localparam logic [25:0] HOLD = 26'd300;
`ifdef PS2_WHEEL_DETECT_EN
  localparam bit WHEEL = 1'b1;
`else
  localparam bit WHEEL = 1'b0;
`endif

  logic clk, rst, rx_valid, tx_busy, tx_error;
  logic [7:0] rx_byte, tx_data;
  logic tx_load, rx_enable, mouse_ready, init_fail, wheel_present;
  logic [3:0] seq_state;

  ps2_mouse_init_seq #(
    .SAMPLE_RATE(8'd100), .RESOLUTION(8'd2), .ACK_TIMEOUT(ACK),
    .BAT_TIMEOUT(BAT), .MAX_RETRIES(3'd3), .FAIL_HOLDOFF(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_busy(tx_busy), .tx_error(tx_error), .tx_data(tx_data), .tx_load(tx_load),
    .rx_enable(rx_enable), .mouse_ready(mouse_ready), .init_fail(init_fail),
    .wheel_present(wheel_present), .seq_state(seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];   // expected tx_data stream
  logic [7:0] inj_q[$];   // bytes to inject while in RUN
  int gap_q[$];           // cycles from FA (of silent FF) to next command
  int silent_ff = 0, err_e8 = 0;
  bit fe_f3 = 0;
  logic [7:0] wheel_id = 8'h03;
  int fail_len = 0, fail_events = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Command script as the device should see it; full=0 is the hot-plug restart (no FF).
  function automatic void script(input bit full, output logic [7:0] s[$]);
    s = {};
    if (full) s.push_back(8'hFF);
    if (WHEEL) begin
      s.push_back(8'hF3); s.push_back(8'hC8); s.push_back(8'hF3); s.push_back(8'h64);
      s.push_back(8'hF3); s.push_back(8'h50); s.push_back(8'hF2);
    end
    s.push_back(8'hF3); s.push_back(8'd100); s.push_back(8'hE8);
    s.push_back(8'd2);  s.push_back(8'hF4);
  endfunction

  task automatic push_script(input bit full);
    logic [7:0] s[$];
    script(full, s);
    foreach (s[i]) exp_q.push_back(s[i]);
  endtask

  task automatic send_rx(input logic [7:0] v);
    repeat ($urandom_range(2, 20)) @(negedge clk);
    rx_byte = v; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Writer + mouse model.
  initial begin : device
    logic [7:0] b, prev_inj;
    int n;
    bit bad;
    tx_busy = 0; tx_error = 0; rx_valid = 0; rx_byte = 0; prev_inj = 0;
    forever begin
      @(negedge clk);
      if (!rst && tx_load && !tx_busy) begin
        b = tx_data; bad = rx_enable; tx_busy = 1;
        repeat ($urandom_range(3, 10)) begin
          @(negedge clk);
          if (rx_enable) bad = 1;
        end
        tx_busy = 0;
        check("rx_enable low while transmitting", bad, 0);
        if (err_e8 > 0 && b == 8'hE8) begin
          err_e8--; tx_error = 1;
          @(negedge clk);
          tx_error = 0;
        end else if (b == 8'hFF) begin
          if (silent_ff > 0) begin
            silent_ff--;
            send_rx(8'hFA);
            n = 0;
            while (!tx_load && n < int'(BAT + HOLD) + 100) begin
              @(negedge clk); n++;
            end
            gap_q.push_back(n);
          end else begin
            send_rx(8'hFA); send_rx(8'hAA); send_rx(8'h00);
          end
        end else if (b == 8'hF3 && fe_f3) begin
          fe_f3 = 0; send_rx(8'hFE);
        end else if (b == 8'hF2) begin
          send_rx(8'hFA); send_rx(wheel_id);
        end else begin
          send_rx(8'hFA);
        end
      end else if (!rst && inj_q.size() > 0) begin
        b = inj_q.pop_front();
        send_rx(b);
        check("mouse_ready after RUN byte", mouse_ready,
              (prev_inj == 8'hAA && b == 8'h00) ? 0 : 1);
        prev_inj = b;
      end
    end
  end

  // Scoreboard monitor: every new load request must match the next scripted byte.
  initial begin : monitor
    logic prev;
    logic [7:0] e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (rst) prev = 0;
      else begin
        if (tx_load && !prev) begin
          if (exp_q.size() == 0) check("unexpected tx_data", tx_data, 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            check("tx_data sequence", tx_data, e);
          end
        end
        prev = tx_load;
      end
    end
  end

  initial begin : fail_mon
    int cur;
    cur = 0;
    forever begin
      @(negedge clk);
      if (init_fail) cur++;
      else if (cur > 0) begin
        fail_len = cur; fail_events++; cur = 0;
      end
    end
  end

  task automatic wait_ready(input int bound, input string name);
    int n;
    n = 0;
    while (!mouse_ready && n < bound) begin
      @(negedge clk); n++;
    end
    check(name, mouse_ready, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    logic [7:0] s[$];
    logic [7:0] b;
    bit first;
    int n;
    rx_byte = 0;
    do_reset();
    check("reset tx_data", tx_data, 8'h00);
    check("reset tx_load", tx_load, 0);
    check("reset rx_enable", rx_enable, 1);
    check("reset mouse_ready", mouse_ready, 0);
    check("reset init_fail", init_fail, 0);
    check("reset wheel_present", wheel_present, 0);

    // Clean bring-up.
    wheel_id = 8'h03;
    push_script(1);
    rst = 0;
    wait_ready(6000, "s1 ready");
    check("s1 init_fail", init_fail, 0);
    check("s1 script consumed", exp_q.size(), 0);
    check("s1 wheel_present", wheel_present, WHEEL ? 1 : 0);

    // RUN: random traffic and a lone AA must not disturb the link.
    repeat (8) begin
      b = 8'($urandom);
      if (b == 8'hAA) b = 8'h55;
      inj_q.push_back(b);
    end
    inj_q.push_back(8'hAA); inj_q.push_back(8'h12);
    n = 0;
    while ((inj_q.size() > 0 || rx_valid) && n < 2000) begin
      @(negedge clk); n++;
    end
    repeat (5) @(negedge clk);
    check("run stays ready", mouse_ready, 1);
    check("run no tx", exp_q.size(), 0);

    // Hot-plug: AA,00 restarts at F3 without FF.
    push_script(0);
    inj_q.push_back(8'hAA); inj_q.push_back(8'h00);
    n = 0;
    while (mouse_ready && n < 2000) begin
      @(negedge clk); n++;
    end
    check("hotplug drops ready", mouse_ready, 0);
    wait_ready(6000, "hotplug ready again");
    check("hotplug script consumed", exp_q.size(), 0);

    // FE on first F3, two tx_errors on E8: retries are per step, so no FAIL.
    do_reset();
    wheel_id = 8'h00; fe_f3 = 1; err_e8 = 2;
    script(1, s);
    first = 1;
    foreach (s[i]) begin
      exp_q.push_back(s[i]);
      if (s[i] == 8'hF3 && first) begin exp_q.push_back(8'hF3); first = 0; end
      if (s[i] == 8'hE8) begin exp_q.push_back(8'hE8); exp_q.push_back(8'hE8); end
    end
    rst = 0;
    wait_ready(8000, "s3 ready");
    check("s3 script consumed", exp_q.size(), 0);
    check("s3 no fail", fail_events, 0);
    check("s3 wheel_present", wheel_present, 0);

    // Silent after FA of FF: three BAT timeouts, FAIL holdoff, then FF again.
    do_reset();
    wheel_id = 8'h03; silent_ff = 3;
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    push_script(1);
    rst = 0;
    wait_ready(10000, "s4 ready");
    check("s4 script consumed", exp_q.size(), 0);
    check("s4 fail events", fail_events, 1);
    check("s4 init_fail length", fail_len, int'(HOLD));
    check("s4 init_fail cleared", init_fail, 0);
    check("s4 gap count", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check_range("s4 bat gap 1", gap_q[0], int'(BAT), int'(BAT) + 4);
      check_range("s4 bat gap 2", gap_q[1], int'(BAT), int'(BAT) + 4);
      check_range("s4 gap with holdoff", gap_q[2], int'(BAT + HOLD), int'(BAT + HOLD) + 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ps2_mouse_init_seq.md
Name: ps2_mouse_init_seq

Overview:
- Power-up and hot-plug controller for the PS/2 mouse port.
- Sequences the shared host-to-device writer and the receiver through a scripted command stream: reset, self-test, sample rate, resolution and stream enable.
- Checks every ACK, retries on failure, and flags the link ready for the packet decoder that feeds the SAM mouse nibble interface.
- Sits between the ps2 port/writer pair and the mouse packet decoder.

Parameters:
SAMPLE_RATE, 8'd100, byte sent after F3 (reports/s)
RESOLUTION, 8'd2, byte sent after E8 (counts/mm code)
ACK_TIMEOUT, 24'd1_000_000, clocks to wait for any expected device byte
BAT_TIMEOUT, 26'd40_000_000, clocks to wait for AA after FF (self-test is slow)
MAX_RETRIES, 3'd3, failed attempts per step before FAIL
FAIL_HOLDOFF, 26'd20_000_000, clocks idle in FAIL before restarting from RESET

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_valid  in  1  one-cycle pulse: receiver delivered rx_byte
rx_byte  in  8  received byte
tx_busy  in  1  writer transmitting
tx_error  in  1  writer reported a framing/no-ack error (pulse)
tx_data  out  8  byte for the writer
tx_load  out  1  load request to the writer
rx_enable  out  1  receiver enable (low while transmitting)
mouse_ready  out  1  stream mode active; decoder may consume packets
init_fail  out  1  retries exhausted; high in FAIL only
wheel_present  out  1  device ID 03 detected (see Optional Feature)
seq_state  out  4  current state code, debug

Behaviour:
- Reset values: tx_data=00, tx_load=0, rx_enable=1, mouse_ready=0, init_fail=0, wheel_present=0, retry count 0. State on reset is SEND, step 0.
- Script, in step order:
  - FF expects FA, then AA, then 00.
  - F3 expects FA; SAMPLE_RATE expects FA.
  - E8 expects FA; RESOLUTION expects FA.
  - F4 expects FA.
- SEND state:
  - Drive tx_data and set tx_load.
  - Hold tx_load until the first cycle tx_busy=1, then clear it.
  - rx_enable=0 from tx_load set until tx_busy falls. Go to WAIT_TX.
- WAIT_TX state:
  - tx_busy falls with no tx_error → WAIT_RSP; timeout counter cleared.
  - tx_error → RETRY.
- WAIT_RSP state:
  - Counter increments each clock. Limit is BAT_TIMEOUT while waiting for AA, else ACK_TIMEOUT.
  - rx_valid with the expected byte → next expected byte, or next step once all expected bytes are seen. Counter is reset on each match.
  - FE (resend), any other byte, or counter reaching the limit → RETRY.
- RETRY state:
  - Retry count +1.
  - If the count reaches MAX_RETRIES → FAIL; otherwise SEND of the same step, with the expectation pointer reset.
  - On advancing to a new step, the retry count clears.
- FAIL state:
  - init_fail=1. Wait FAIL_HOLDOFF clocks, then clear init_fail and the retry count, and go to step 0.
- RUN state (entered after the F4 ACK):
  - mouse_ready=1, rx_enable=1.
  - Detect AA followed by 00 on consecutive rx_valid events (hot-plug or device reset): drop mouse_ready the cycle after the 00 and restart at the F3 step. The FF step is not resent.
  - A lone AA followed by any other byte is ignored.
- rx_valid outside WAIT_RSP and RUN is ignored.
- rx_valid and timeout in the same cycle: rx_valid wins.
- rst at any point, including mid-transmit, aborts immediately to the reset values. The writer is not told; it finishes or errors independently.

Optional Feature:
- Macro: PS2_WHEEL_DETECT_EN.
- Defined: after the 00 from FF, insert the steps F3,C8 / F3,64 / F3,50 / F2. Every byte expects FA; F2 additionally captures the next rx byte as ID.
  - ID=03 → wheel_present=1.
  - Any ID value is accepted.
  - wheel_present is cleared on rst and on every restart at step 0.
- Not defined: those steps are absent and wheel_present is tied 0.

Test Plan:
- Model answers FA, AA, 00, then FA to every byte → tx_data sequence FF, F3, 64, E8, 02, F4; mouse_ready=1 after the last FA; init_fail=0.
- Model answers FE to the first F3, then FA → F3 resent exactly once; sequence completes; retry count back to 0 at E8.
- Model silent after FF → no byte for BAT_TIMEOUT, three FF attempts, init_fail=1 for FAIL_HOLDOFF clocks, then FF resent.
- In RUN, inject AA then 00 → mouse_ready falls; next tx_data=F3, not FF; ready again after the F4 ACK.
- tx_error pulse during E8 transmit → RETRY; E8 resent; rx_enable=0 throughout each transmit.
- With PS2_WHEEL_DETECT_EN defined, model returns ID 03 → wheel_present=1 and normal script completes; ID 00 → wheel_present=0.
